// File: rtl/wb_stage_pkg.sv
// Shared pipeline encodings for the write-back stage: write-data select, destination select
// and load type, plus the load misalignment rule.
package wb_stage_pkg;

    localparam logic [1:0] WD_ALU  = 2'd0;
    localparam logic [1:0] WD_LOAD = 2'd1;
    localparam logic [1:0] WD_LINK = 2'd2;

    localparam logic [1:0] DST_RT   = 2'd0;
    localparam logic [1:0] DST_RD   = 2'd1;
    localparam logic [1:0] DST_LINK = 2'd2;

    localparam logic [2:0] LD_WORD  = 3'd0;
    localparam logic [2:0] LD_BYTE  = 3'd1;
    localparam logic [2:0] LD_BYTEU = 3'd2;
    localparam logic [2:0] LD_HALF  = 3'd3;
    localparam logic [2:0] LD_HALFU = 3'd4;

    // Bytes are always aligned; unknown load types behave as word loads.
    function automatic logic load_misaligned(input logic [2:0] ld_type, input logic [1:0] a);
        logic result;
        result = 1'b0;
        case (ld_type)
            LD_BYTE, LD_BYTEU: result = 1'b0;
            LD_HALF, LD_HALFU: result = a[0];
            default:           result = (a != 2'd0);
        endcase
        return result;
    endfunction

endpackage

// File: rtl/wb_load_ext.sv
// Load alignment and extension: picks the addressed byte/half from the raw memory word
// and sign- or zero-extends it to the register width.
module wb_load_ext
    import wb_stage_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [2:0]        ld_type,
    input  logic [1:0]        addr_lo,
    input  logic [DATA_W-1:0] mem,
    output logic [DATA_W-1:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = mem[{addr_lo, 3'b000} +: 8];
        half_v = mem[{addr_lo[1], 4'b0000} +: 16];
        case (ld_type)
            LD_BYTE:  data = {{(DATA_W-8){byte_v[7]}}, byte_v};
            LD_BYTEU: data = {{(DATA_W-8){1'b0}}, byte_v};
            LD_HALF:  data = {{(DATA_W-16){half_v[15]}}, half_v};
            LD_HALFU: data = {{(DATA_W-16){1'b0}}, half_v};
            default:  data = mem;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Pipeline write-back stage: W register, register-file write port, misaligned-load pulse and
// retire counter. Defining WB_FWD_EN adds the fwd_valid/fwd_addr/fwd_data forwarding port.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LINK_REG = 31,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m_valid,
    input  logic              hold,
    input  logic              flush,
    input  logic              m_reg_write,
    input  logic [1:0]        m_wd_sel,
    input  logic [1:0]        m_dst_sel,
    input  logic [2:0]        m_ld_type,
    input  logic [REG_AW-1:0] m_rt,
    input  logic [REG_AW-1:0] m_rd,
    input  logic [DATA_W-1:0] m_alu,
    input  logic [DATA_W-1:0] m_mem,
    input  logic [DATA_W-1:0] m_pc,
`ifdef WB_FWD_EN
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_addr,
    output logic [DATA_W-1:0] fwd_data,
`endif
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              misalign,
    output logic [CNT_W-1:0]  retire_cnt
);

    logic              w_valid;
    logic              done;
    logic              w_reg_write;
    logic [1:0]        w_wd_sel;
    logic [1:0]        w_dst_sel;
    logic [2:0]        w_ld_type;
    logic [REG_AW-1:0] w_rt;
    logic [REG_AW-1:0] w_rd;
    logic [DATA_W-1:0] w_alu;
    logic [DATA_W-1:0] w_mem;
    logic [DATA_W-1:0] w_pc;

    logic [DATA_W-1:0] load_data;
    logic              misaligned;
    logic              first_cycle;
    logic              writable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_valid     <= 1'b0;
            done        <= 1'b0;
            w_reg_write <= 1'b0;
            w_wd_sel    <= 2'd0;
            w_dst_sel   <= 2'd0;
            w_ld_type   <= 3'd0;
            w_rt        <= '0;
            w_rd        <= '0;
            w_alu       <= '0;
            w_mem       <= '0;
            w_pc        <= '0;
        end else if (flush) begin
            w_valid <= 1'b0;
            done    <= 1'b0;
        end else if (!hold) begin
            w_valid <= m_valid;
            done    <= 1'b0;
            if (m_valid) begin
                w_reg_write <= m_reg_write;
                w_wd_sel    <= m_wd_sel;
                w_dst_sel   <= m_dst_sel;
                w_ld_type   <= m_ld_type;
                w_rt        <= m_rt;
                w_rd        <= m_rd;
                w_alu       <= m_alu;
                w_mem       <= m_mem;
                w_pc        <= m_pc;
            end
        end else begin
            // Under hold the instruction has been presented once; suppress repeat writes.
            done <= done | w_valid;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retire_cnt <= '0;
        end else if (first_cycle) begin
            retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

    wb_load_ext #(
        .DATA_W (DATA_W)
    ) u_load_ext (
        .ld_type (w_ld_type),
        .addr_lo (w_alu[1:0]),
        .mem     (w_mem),
        .data    (load_data)
    );

    always_comb begin
        case (w_dst_sel)
            DST_RD:   rf_waddr = w_rd;
            DST_LINK: rf_waddr = REG_AW'(LINK_REG);
            default:  rf_waddr = w_rt;
        endcase
        case (w_wd_sel)
            WD_LOAD: rf_wdata = load_data;
            WD_LINK: rf_wdata = w_pc + DATA_W'(8);
            default: rf_wdata = w_alu;
        endcase
    end

    assign misaligned  = (w_wd_sel == WD_LOAD) && load_misaligned(w_ld_type, w_alu[1:0]);
    assign first_cycle = w_valid & ~done;
    assign writable    = w_valid & w_reg_write & (rf_waddr != '0) & ~misaligned;
    assign rf_we       = writable & ~done;
    assign misalign    = first_cycle & misaligned;

`ifdef WB_FWD_EN
    assign fwd_valid = writable;
    assign fwd_addr  = rf_waddr;
    assign fwd_data  = rf_wdata;
`endif

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register-file data width (multiple of 32 only; 32 is the only tested value).
REQ-002 SHALL have parameter REG_AW, default 5, register address width.
REQ-003 SHALL have parameter LINK_REG, default 31, destination index for link writes.
REQ-004 SHALL have parameter CNT_W, default 32, width of the retire counter.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 m_valid  in  1  M stage presents an instruction this cycle.
REQ-008 hold  in  1  freeze W register; current contents retained.
REQ-009 flush  in  1  discard W contents and incoming instruction.
REQ-010 m_reg_write  in  1  instruction writes a register.
REQ-011 m_wd_sel  in  2  0=ALU result, 1=load data, 2=link (PC+8); 3 reserved, treated as 0.
REQ-012 m_dst_sel  in  2  0=rt, 1=rd, 2=LINK_REG; 3 reserved, treated as 0.
REQ-013 m_ld_type  in  3  0=word, 1=byte signed, 2=byte unsigned, 3=half signed, 4=half unsigned; others treated as word.
REQ-014 m_rt, m_rd  in  REG_AW each  candidate destinations.
REQ-015 m_alu, m_mem, m_pc  in  DATA_W each  ALU result/address, raw memory word, instruction PC.
REQ-016 rf_we  out  1  register-file write enable.
REQ-017 rf_waddr  out  REG_AW  write address.
REQ-018 rf_wdata  out  DATA_W  write data.
REQ-019 misalign  out  1  one-cycle pulse, misaligned load retiring.
REQ-020 retire_cnt  out  CNT_W  count of instructions retired.

Function
REQ-021 W register SHALL capture all m_* fields when m_valid=1, hold=0, flush=0; w_valid<=1.
REQ-022 W register SHALL set w_valid<=0 when m_valid=0, hold=0, flush=0.
REQ-023 hold=1, flush=0 SHALL retain all W contents and w_valid unchanged.
REQ-024 flush=1 SHALL clear w_valid next edge regardless of hold or m_valid (flush wins).
REQ-025 Latency SHALL be one cycle: instruction captured at edge N drives rf_* during cycle N..N+1.
REQ-026 done flag SHALL set after first cycle a valid W instruction is presented and clear on any new capture or flush; rf_we SHALL be 0 while done=1 (no repeated write under hold).
REQ-027 rf_we SHALL equal w_valid & !done & w_reg_write & (rf_waddr!=0) & !misaligned.
REQ-028 rf_waddr SHALL be rt, rd or LINK_REG per w_dst_sel.
REQ-029 Load data SHALL select byte m_mem[8*a+7:8*a] or half m_mem[16*a[1]+15:16*a[1]], a=w_alu[1:0], sign- or zero-extended to DATA_W per ld_type.
REQ-030 Link data SHALL be w_pc+8, modulo 2^DATA_W.
REQ-031 Misaligned SHALL mean wd_sel=1 and (word with a!=0, or half with a[0]=1); misalign SHALL pulse for exactly one cycle under the same valid/done qualification as rf_we.
REQ-032 retire_cnt SHALL increment once per instruction on its first presented cycle (w_valid & !done), including misaligned and non-writing ones; wraps to 0.
REQ-033 rf_wdata SHALL be don't-care when rf_we=0 but SHALL not be X after reset.

Reset
REQ-034 reset SHALL asynchronously clear w_valid, done, retire_cnt and all W data fields to 0; rf_we=0, misalign=0, rf_waddr=0, rf_wdata=0.
REQ-035 Reset mid-hold SHALL drop the held instruction; no write after release.

Configuration
REQ-036 With WB_FWD_EN defined, SHALL add outputs fwd_valid (1), fwd_addr (REG_AW), fwd_data (DATA_W) equal to w_valid & w_reg_write & addr!=0 & !misaligned, rf_waddr, rf_wdata, held asserted through hold (ignoring done).
REQ-037 Without WB_FWD_EN, those ports SHALL not exist; all other behaviour identical.

Structure
REQ-038 wd_sel, dst_sel and ld_type encodings SHALL be constants in the shared pipeline package.
REQ-039 Load alignment/extension SHALL be sub-module wb_load_ext (combinational, parameter DATA_W).

Verification
REQ-040 lb, m_alu=0x1003, m_mem=0x80FF_0000, rt=8 -> next cycle rf_we=1, waddr=8, wdata=0xFFFF_FF80.
REQ-041 jal, m_pc=0x0000_3000 -> waddr=31, wdata=0x0000_3008, retire_cnt +1.
REQ-042 lw to rd=0 -> rf_we=0, retire_cnt +1.
REQ-043 lh, m_alu=0x1001 -> misalign=1 one cycle, rf_we=0.
REQ-044 addu captured then hold=1 for 3 cycles -> rf_we=1 exactly one cycle, retire_cnt +1 total; flush+hold same cycle -> w_valid=0.
REQ-045 reset asserted mid-hold -> outputs 0 immediately, no write after release.
